updown_counter: RTL and testbench



---
 rtl/updown_counter_if.sv | 34 +++
 rtl/updown_counter.sv | 94 +++++++++
 tb/tb_updown_counter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/updown_counter_if.sv
// updown_counter_if -- control/status bundle of the up/down counter.
//   sclk     : divided clock from clock_divider, sampled as plain data
//   en, up   : count enable and direction (1 = up)
//   load     : synchronous load strobe, load_val is the value loaded
//   count    : current count
//   dir      : registered direction (holds its last value while disabled)
//   tc       : one-cycle terminal-count pulse
//   cnt_zero : count == 0 (combinational)
//   cnt_max  : count == all ones (combinational)
// master = the block driving the controls, slave = the counter.
interface updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             sclk;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             tc;
  logic             cnt_zero;
  logic             cnt_max;

  modport master (
    output sclk, en, up, load, load_val,
    input  count, dir, tc, cnt_zero, cnt_max
  );

  modport slave (
    input  sclk, en, up, load, load_val,
    output count, dir, tc, cnt_zero, cnt_max
  );
endinterface

// File: rtl/updown_counter.sv
// updown_counter -- up/down counter stepped once per rising edge of sclk.
// sclk is a slow level from the clock divider; it is synchronised and
// edge-detected on clk and never used as a clock.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : updown_counter_if.slave (sclk/en/up/load/load_val in,
//           count/dir/tc/cnt_zero/cnt_max out)
// Parameters:
//   WIDTH : counter width
//   WRAP  : 1 = wrap around at the bounds, 0 = saturate at the bounds
module updown_counter #(
  parameter int WIDTH = 4,
  parameter int WRAP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  updown_counter_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  logic             r_s1, r_s2, r_s3;
  state_t           r_state;
  logic             r_dir;
  logic             r_tc;
  logic [WIDTH-1:0] r_count;

  logic             w_tick;
  logic             w_at_max;
  logic             w_at_zero;

  // r_s1/r_s2 synchronise sclk; r_s3 is the delayed copy for edge detect.
  assign w_tick    = r_s2 & ~r_s3;
  assign w_at_max  = (r_count == {WIDTH{1'b1}});
  assign w_at_zero = (r_count == {WIDTH{1'b0}});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_state <= ST_HOLD;
      r_dir   <= 1'b1;
      r_tc    <= 1'b0;
      r_count <= '0;
    end else begin
      r_s1 <= bus.sclk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;

      // Mode register follows en/up every cycle; the count below uses the
      // registered mode, so a mode change lags by one clk.
      if (!bus.en) begin
        r_state <= ST_HOLD;
      end else if (bus.up) begin
        r_state <= ST_UP;
        r_dir   <= 1'b1;
      end else begin
        r_state <= ST_DOWN;
        r_dir   <= 1'b0;
      end

      r_tc <= 1'b0;
      if (bus.load) begin
        // Load beats a coincident tick; that tick is dropped, not deferred.
        r_count <= bus.load_val;
      end else if (w_tick) begin
        case (r_state)
          ST_UP: begin
            r_tc <= w_at_max;
            if (!w_at_max || (WRAP != 0)) r_count <= r_count + WIDTH'(1);
          end
          ST_DOWN: begin
            r_tc <= w_at_zero;
            if (!w_at_zero || (WRAP != 0)) r_count <= r_count - WIDTH'(1);
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.dir      = r_dir;
  assign bus.tc       = r_tc;
  assign bus.cnt_zero = w_at_zero;
  assign bus.cnt_max  = w_at_max;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: a wrapping instance (dut0) and a saturating
// instance (dut1) share clk, reset and sclk. Stimulus comes from a vector
// table plus hand-written corner sequences; every sclk pulse pushes its
// expected outcome into a queue which a monitor pops two clk edges after
// it sees sclk first sampled high.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sclk = 1'b0;
  logic       en = 1'b0, up = 1'b0, load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       en1 = 1'b0, up1 = 1'b0, load1 = 1'b0;
  logic [3:0] load_val1 = 4'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  updown_counter_if #(.WIDTH(4)) bus0 ();
  updown_counter_if #(.WIDTH(4)) bus1 ();

  assign bus0.sclk = sclk;  assign bus1.sclk = sclk;
  assign bus0.en   = en;    assign bus1.en   = en1;
  assign bus0.up   = up;    assign bus1.up   = up1;
  assign bus0.load = load;  assign bus1.load = load1;
  assign bus0.load_val = load_val;
  assign bus1.load_val = load_val1;

  updown_counter #(.WIDTH(4), .WRAP(1)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  updown_counter #(.WIDTH(4), .WRAP(0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  typedef struct {
    logic [3:0] cnt;
    logic       tc;
    logic       dir;
    bit         chk1;
    logic [3:0] cnt1;
    logic       tc1;
  } exp_t;

  typedef struct {
    bit         en, up, ld;
    logic [3:0] lval;
    logic [3:0] cnt;
    logic       tc;
    logic       dir;
  } vec_t;

  exp_t sb[$];
  vec_t vec[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // One sclk period: 2 clk high, 2 clk low. Called just after a negedge.
  task automatic pulse(exp_t e);
    sb.push_back(e);
    sclk = 1'b1;
    cyc(2);
    sclk = 1'b0;
    cyc(2);
  endtask

  function automatic exp_t ex0(logic [3:0] c, logic t, logic d);
    exp_t e;
    e.cnt = c; e.tc = t; e.dir = d; e.chk1 = 1'b0; e.cnt1 = 4'd0; e.tc1 = 1'b0;
    return e;
  endfunction

  function automatic exp_t ex1(logic [3:0] c, logic t, logic d, logic [3:0] c1, logic t1);
    exp_t e;
    e = ex0(c, t, d);
    e.chk1 = 1'b1; e.cnt1 = c1; e.tc1 = t1;
    return e;
  endfunction

  function automatic vec_t mk(bit e, bit u, bit l, logic [3:0] lv,
                              logic [3:0] c, logic t, logic d);
    vec_t v;
    v.en = e; v.up = u; v.ld = l; v.lval = lv; v.cnt = c; v.tc = t; v.dir = d;
    return v;
  endfunction

  // Independent view of when a count step is due: edge N is the first
  // non-reset edge sampling sclk high; the result is visible after edge N+2.
  logic    prev_sclk = 1'b0;
  int      cd = 0;
  logic    fire = 1'b0;
  logic    tc_follow = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      prev_sclk <= 1'b0;
      cd        <= 0;
    end else begin
      prev_sclk <= sclk;
      if (sclk && !prev_sclk) cd <= 2;
      else if (cd != 0)       cd <= cd - 1;
    end
    fire      <= !reset && (cd == 1);
    tc_follow <= fire;
  end

  always @(negedge clk) begin
    exp_t e;
    if (tc_follow) check("tc_width", 32'(bus0.tc), 32'd0);
    if (fire) begin
      if (sb.size() == 0) begin
        check("unexpected_step", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("cnt",      32'(bus0.count),    32'(e.cnt));
        check("tc",       32'(bus0.tc),       32'(e.tc));
        check("dir",      32'(bus0.dir),      32'(e.dir));
        check("cnt_zero", 32'(bus0.cnt_zero), 32'(e.cnt == 4'd0));
        check("cnt_max",  32'(bus0.cnt_max),  32'(e.cnt == 4'hf));
        if (e.chk1) begin
          check("sat_cnt", 32'(bus1.count),   32'(e.cnt1));
          check("sat_tc",  32'(bus1.tc),      32'(e.tc1));
          check("sat_max", 32'(bus1.cnt_max), 32'(e.cnt1 == 4'hf));
        end
      end
    end
  end

  initial begin
    // Table: basic up run with wrap, load + down wrap, hold, direction
    // changes, loads of bound values.
    for (int i = 0; i < 16; i++)
      vec.push_back(mk(1, 1, 0, 4'd0, 4'(i + 1), i == 15, 1'b1));
    vec.push_back(mk(1, 0, 1, 4'd3, 4'd3,  1'b0, 1'b0));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd2,  1'b0, 1'b0));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd1,  1'b0, 1'b0));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd0,  1'b0, 1'b0));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd15, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++)
      vec.push_back(mk(0, 0, 0, 4'd0, 4'd15, 1'b0, 1'b0));
    vec.push_back(mk(1, 1, 0, 4'd0, 4'd0,  1'b1, 1'b1));
    vec.push_back(mk(1, 1, 0, 4'd0, 4'd1,  1'b0, 1'b1));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd0,  1'b0, 1'b0));
    vec.push_back(mk(1, 0, 0, 4'd0, 4'd15, 1'b1, 1'b0));
    vec.push_back(mk(0, 0, 1, 4'd0, 4'd0,  1'b0, 1'b0));
    vec.push_back(mk(0, 0, 1, 4'd15, 4'd15, 1'b0, 1'b0));

    // Reset state
    cyc(2);
    check("rst_cnt",  32'(bus0.count),    32'd0);
    check("rst_tc",   32'(bus0.tc),       32'd0);
    check("rst_dir",  32'(bus0.dir),      32'd1);
    check("rst_zero", 32'(bus0.cnt_zero), 32'd1);
    check("rst_max",  32'(bus0.cnt_max),  32'd0);
    reset = 1'b0;
    cyc(1);

    foreach (vec[i]) begin
      en = vec[i].en;
      up = vec[i].up;
      if (vec[i].ld) begin
        load = 1'b1;
        load_val = vec[i].lval;
        cyc(1);
        load = 1'b0;
        check("load_cnt", 32'(bus0.count), 32'(vec[i].cnt));
        check("load_tc",  32'(bus0.tc),    32'd0);
        check("load_dir", 32'(bus0.dir),   32'(vec[i].dir));
        cyc(1);
        check("load_tc2", 32'(bus0.tc),    32'd0);
      end else begin
        pulse(ex0(vec[i].cnt, vec[i].tc, vec[i].dir));
      end
    end

    // en drops while the tick is in flight: step still happens (15->14),
    // the following tick is held.
    en = 1'b1; up = 1'b0;
    sb.push_back(ex0(4'd14, 1'b0, 1'b0));
    sclk = 1'b1;
    cyc(2);
    en = 1'b0;
    sclk = 1'b0;
    cyc(2);
    pulse(ex0(4'd14, 1'b0, 1'b0));

    // load coincides with the tick: load wins, tick is lost.
    en = 1'b1; up = 1'b1;
    sb.push_back(ex0(4'd9, 1'b0, 1'b1));
    sclk = 1'b1;
    cyc(2);
    load = 1'b1; load_val = 4'd9;
    sclk = 1'b0;
    cyc(1);
    load = 1'b0;
    cyc(3);
    check("no_deferred_tick", 32'(bus0.count), 32'd9);
    pulse(ex0(4'd10, 1'b0, 1'b1));

    // Reset during the sclk high phase, held until sclk is low.
    sclk = 1'b1;
    cyc(1);
    reset = 1'b1;
    cyc(1);
    sclk = 1'b0;
    cyc(2);
    check("midrst_cnt",  32'(bus0.count),    32'd0);
    check("midrst_zero", 32'(bus0.cnt_zero), 32'd1);
    check("midrst_max",  32'(bus0.cnt_max),  32'd0);
    check("midrst_dir",  32'(bus0.dir),      32'd1);
    reset = 1'b0;
    cyc(4);
    check("post_rst_cnt", 32'(bus0.count), 32'd0);
    check("post_rst_tc",  32'(bus0.tc),    32'd0);

    // sclk already high at reset release: one step, 2 edges after release.
    reset = 1'b1;
    sclk = 1'b1;
    cyc(2);
    sb.push_back(ex0(4'd1, 1'b0, 1'b1));
    reset = 1'b0;
    cyc(2);
    check("latency_not_early", 32'(bus0.count), 32'd0);
    sclk = 1'b0;
    cyc(4);

    // Saturating instance: up from 14, then down from 1.
    en = 1'b0;
    en1 = 1'b1; up1 = 1'b1; load1 = 1'b1; load_val1 = 4'd14;
    cyc(1);
    load1 = 1'b0;
    check("sat_load", 32'(bus1.count), 32'd14);
    pulse(ex1(4'd1, 1'b0, 1'b1, 4'd15, 1'b0));
    pulse(ex1(4'd1, 1'b0, 1'b1, 4'd15, 1'b1));
    pulse(ex1(4'd1, 1'b0, 1'b1, 4'd15, 1'b1));
    up1 = 1'b0; load1 = 1'b1; load_val1 = 4'd1;
    cyc(1);
    load1 = 1'b0;
    check("sat_load2", 32'(bus1.count), 32'd1);
    pulse(ex1(4'd1, 1'b0, 1'b1, 4'd0, 1'b0));
    pulse(ex1(4'd1, 1'b0, 1'b1, 4'd0, 1'b1));
    check("sat_zero", 32'(bus1.cnt_zero), 32'd1);

    cyc(4);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
